dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Single-port access arbiter for the 64-word data memory. Shares one memory port between three requesters: the CPU (read/write), the keyboard writer (write only) and the VGA reader (read only). Access uses a req/ack handshake, with read data returned one cycle after ack. After every reset the block runs a hardware clear sweep that zeroes the whole memory before accepting requests, so the memory needs no reset of its own.

## Interface
Parameters:
- DEPTH, 64, memory words; word index = byte address [31:2]
- STARVE_LIMIT, 8, wait cycles after which a pending lower-priority request is promoted

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- cpu_req  input  1  CPU access request, held until cpu_ack
- cpu_we  input  1  1 = write, 0 = read
- cpu_a  input  32  CPU byte address
- cpu_wd  input  32  CPU write data
- cpu_ack  output  1  access performed this cycle
- cpu_rvalid  output  1  cpu_rd valid, one cycle after a read ack
- cpu_rd  output  32  CPU read data
- kb_req  input  1  keyboard write request
- kb_a  input  32  keyboard byte address
- kb_wd  input  32  keyboard write data
- kb_ack  output  1  keyboard write performed
- vga_req  input  1  VGA read request
- vga_a  input  32  VGA byte address
- vga_ack  output  1  VGA read performed
- vga_rvalid  output  1  vga_rd valid
- vga_rd  output  32  VGA read data
- mem_we  output  1  memory write enable
- mem_a  output  32  memory byte address
- mem_wd  output  32  memory write data
- mem_rd  input  32  memory combinational read data at mem_a
- ready  output  1  high in RUN
- addr_err  output  1  one-cycle pulse with an ack for an out-of-range address

## Operation
- The FSM has two states, CLEAR and RUN. A cycle with rst high loads CLEAR with clr_idx=0.
  - During the rst cycle itself: mem_we=0 and all acks are 0.
- CLEAR:
  - Each cycle drives mem_we=1, mem_a={clr_idx,2'b00} and mem_wd=0, then increments clr_idx.
  - After the write at clr_idx=DEPTH-1, the next state is RUN.
  - No acks are issued in CLEAR; requests stay pending and their wait counters do not run.
- RUN: at most one grant per cycle.
  - If any requesting agent has wait count == STARVE_LIMIT, the highest fixed-priority starving agent wins.
  - Otherwise the fixed priority CPU > KB > VGA applies.
- On a grant:
  - The winner's mem_a, mem_wd and we drive the memory combinationally.
  - The winner's ack is 1 in the same cycle, and the write commits at that clock edge.
  - If no agent is granted, mem_we=0 and mem_a=0.
- Range check: an address is in range when a[31:2] < DEPTH; a[1:0] is ignored. Out of range:
  - ack is still given and addr_err=1 that cycle.
  - mem_we is forced to 0.
  - A read returns 0.
- Read return: on a read ack, mem_rd (or 0 if out of range) is registered into cpu_rd or vga_rd, and rvalid is 1 for exactly the next cycle.
  - rd holds its last value otherwise.
- Wait counter, one per agent, saturating at STARVE_LIMIT:
  - Increments in RUN each cycle req=1 and ack=0.
  - Clears on ack or when req=0.
- A req held high after its ack is a new request, arbitrated the next cycle. Back-to-back accesses are therefore possible at one per cycle.
- Requesters must hold address and data stable while req=1 without ack. The block does not register request fields.

## Timing
- Reset values: ready=0, all rvalid=0, cpu_rd=vga_rd=0, addr_err=0, all acks 0, counters 0, clr_idx=0.
- The clear sweep takes exactly DEPTH cycles after rst falls. ready rises in the cycle after the last clear write.
- Uncontended latency: ack in the same cycle as req; rvalid and data one cycle later.
- Worst-case wait for KB or VGA: STARVE_LIMIT cycles, plus one cycle if both are starving together.
- rst mid-operation:
  - Aborts any access in that cycle (no write, no ack).
  - Drops rvalid the next cycle.
  - Restarts CLEAR.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum {CLEAR, RUN}
  - the agent index enum {AG_CPU, AG_KB, AG_VGA}
  - the default DEPTH and STARVE_LIMIT constants
- Sub-module dmem_arb_wait_ctr is the saturating per-agent wait counter (inputs req, ack, run; output starving). It is instantiated three times.

## Test plan
- Release rst → 64 consecutive writes of 0 to addresses 0x00..0xFC, ready=1 on cycle 65, no acks before that.
- CPU writes 0xDEADBEEF to 0x10, then reads 0x10 → cpu_ack on each request cycle; cpu_rvalid one cycle after the read ack with cpu_rd=0xDEADBEEF.
- CPU, KB and VGA all request in the same cycle, and CPU re-requests continuously → grants CPU×8, then KB once its count hits 8, then VGA the next cycle.
- VGA reads 0x100 (index 64) → vga_ack and addr_err together, mem_we=0, vga_rd=0 with vga_rvalid next cycle. A KB write to 0x100 is acked with no memory write.
- rst pulsed while the KB write is pending → no kb_ack, rvalid cleared, clear sweep restarts at index 0, KB write acked only after ready.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter: FSM states, agent
// indices and the word-range check applied to every requester address.
package dmem_arb_pkg;

  localparam int DEPTH_DEF        = 64;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    AG_CPU = 2'd0,
    AG_KB  = 2'd1,
    AG_VGA = 2'd2
  } agent_t;

  // Word index is the byte address with the two byte-lane bits dropped.
  function automatic logic in_range(input logic [31:0] a, input int depth);
    return ({2'b00, a[31:2]} < 32'(depth));
  endfunction

endpackage

// File: rtl/dmem_arb_wait_ctr.sv
// Saturating wait counter for one requester; flags the agent as starving
// once it has waited STARVE_LIMIT cycles with its request still up.
module dmem_arb_wait_ctr
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack,
  input  logic run,
  output logic starving
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] cnt;

  // Counter only advances while arbitration runs; it holds during the clear sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!req || ack) begin
      cnt <= '0;
    end else if (run && (cnt != CW'(STARVE_LIMIT))) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign starving = req && (cnt == CW'(STARVE_LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port arbiter for the data memory: clears the memory after reset,
// then grants one of CPU / keyboard / VGA per cycle with starvation promotion.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_a,
  input  logic [31:0] cpu_wd,
  output logic        cpu_ack,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rd,
  input  logic        kb_req,
  input  logic [31:0] kb_a,
  input  logic [31:0] kb_wd,
  output logic        kb_ack,
  input  logic        vga_req,
  input  logic [31:0] vga_a,
  output logic        vga_ack,
  output logic        vga_rvalid,
  output logic [31:0] vga_rd,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        ready,
  output logic        addr_err
);

  localparam int IW = $clog2(DEPTH);

  state_t        state;
  state_t        next_state;
  logic [IW-1:0] clr_idx;
  logic          run;
  logic          starve_cpu;
  logic          starve_kb;
  logic          starve_vga;
  logic          gnt;
  agent_t        winner;
  logic [31:0]   sel_a;
  logic [31:0]   sel_wd;
  logic          sel_we;
  logic          sel_ok;

  assign run   = (state == RUN) && !rst;
  assign ready = (state == RUN);

  dmem_arb_wait_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_wait_cpu (
    .clk(clk), .rst(rst), .req(cpu_req), .ack(cpu_ack), .run(run), .starving(starve_cpu)
  );
  dmem_arb_wait_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_wait_kb (
    .clk(clk), .rst(rst), .req(kb_req), .ack(kb_ack), .run(run), .starving(starve_kb)
  );
  dmem_arb_wait_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_wait_vga (
    .clk(clk), .rst(rst), .req(vga_req), .ack(vga_ack), .run(run), .starving(starve_vga)
  );

  // State register and clear-sweep index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= next_state;
      if (state == CLEAR) begin
        clr_idx <= clr_idx + IW'(1);
      end else begin
        clr_idx <= clr_idx;
      end
    end
  end

  // Leave CLEAR once the last word has been written.
  always_comb begin
    next_state = state;
    case (state)
      CLEAR: begin
        if (clr_idx == IW'(DEPTH - 1)) begin
          next_state = RUN;
        end else begin
          next_state = CLEAR;
        end
      end
      RUN:     next_state = RUN;
      default: next_state = CLEAR;
    endcase
  end

  // Arbitration and memory-port drive; a starving agent outranks plain priority.
  always_comb begin
    gnt      = 1'b0;
    winner   = AG_CPU;
    sel_a    = 32'h0;
    sel_wd   = 32'h0;
    sel_we   = 1'b0;
    sel_ok   = 1'b0;
    cpu_ack  = 1'b0;
    kb_ack   = 1'b0;
    vga_ack  = 1'b0;
    addr_err = 1'b0;
    mem_we   = 1'b0;
    mem_a    = 32'h0;
    mem_wd   = 32'h0;
    if (run) begin
      gnt = 1'b1;
      if (starve_cpu)      winner = AG_CPU;
      else if (starve_kb)  winner = AG_KB;
      else if (starve_vga) winner = AG_VGA;
      else if (cpu_req)    winner = AG_CPU;
      else if (kb_req)     winner = AG_KB;
      else if (vga_req)    winner = AG_VGA;
      else                 gnt    = 1'b0;
    end else begin
      gnt = 1'b0;
    end
    case (winner)
      AG_CPU: begin sel_a = cpu_a; sel_wd = cpu_wd; sel_we = cpu_we; end
      AG_KB:  begin sel_a = kb_a;  sel_wd = kb_wd;  sel_we = 1'b1;   end
      AG_VGA: begin sel_a = vga_a; sel_wd = 32'h0;  sel_we = 1'b0;   end
      default: begin sel_a = 32'h0; sel_wd = 32'h0; sel_we = 1'b0;   end
    endcase
    sel_ok   = in_range(sel_a, DEPTH);
    cpu_ack  = gnt && (winner == AG_CPU);
    kb_ack   = gnt && (winner == AG_KB);
    vga_ack  = gnt && (winner == AG_VGA);
    addr_err = gnt && !sel_ok;
    if (!rst && (state == CLEAR)) begin
      mem_we = 1'b1;
      mem_a  = {{(30 - IW){1'b0}}, clr_idx, 2'b00};
      mem_wd = 32'h0;
    end else if (gnt) begin
      mem_we = sel_we && sel_ok;
      mem_a  = sel_a;
      mem_wd = sel_wd;
    end else begin
      mem_we = 1'b0;
      mem_a  = 32'h0;
      mem_wd = 32'h0;
    end
  end

  // Read return path: data lands one cycle after the read ack and then holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rvalid <= 1'b0;
      vga_rvalid <= 1'b0;
      cpu_rd     <= 32'h0;
      vga_rd     <= 32'h0;
    end else begin
      cpu_rvalid <= cpu_ack && !cpu_we;
      vga_rvalid <= vga_ack;
      if (cpu_ack && !cpu_we) begin
        cpu_rd <= sel_ok ? mem_rd : 32'h0;
      end else begin
        cpu_rd <= cpu_rd;
      end
      if (vga_ack) begin
        vga_rd <= sel_ok ? mem_rd : 32'h0;
      end else begin
        vga_rd <= vga_rd;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 64-word memory and
// read-data scoreboards checked whenever an rvalid appears.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, kb_req, vga_req;
  logic [31:0] cpu_a, cpu_wd, kb_a, kb_wd, vga_a;
  logic        cpu_ack, cpu_rvalid, kb_ack, vga_ack, vga_rvalid;
  logic [31:0] cpu_rd, vga_rd;
  logic        mem_we, ready, addr_err;
  logic [31:0] mem_a, mem_wd, mem_rd;

  logic [31:0] mem [0:63];
  logic [31:0] cpu_q [$];
  logic [31:0] vga_q [$];
  int          n_checks = 0;
  int          n_err    = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_wd(cpu_wd),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rd(cpu_rd),
    .kb_req(kb_req), .kb_a(kb_a), .kb_wd(kb_wd), .kb_ack(kb_ack),
    .vga_req(vga_req), .vga_a(vga_a), .vga_ack(vga_ack),
    .vga_rvalid(vga_rvalid), .vga_rd(vga_rd),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .ready(ready), .addr_err(addr_err)
  );

  // Out-of-range addresses read garbage so the arbiter's zero-forcing is visible.
  assign mem_rd = (mem_a[31:8] == 24'h0) ? mem[mem_a[7:2]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (cpu_rvalid === 1'b1) begin
      if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'h0);
      else                   check("cpu_rd", cpu_rd, cpu_q.pop_front());
    end
    if (vga_rvalid === 1'b1) begin
      if (vga_q.size() == 0) check("vga_rvalid_unexpected", 32'(vga_rvalid), 32'h0);
      else                   check("vga_rd", vga_rd, vga_q.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = 32'h0; cpu_wd = 32'h0;
    kb_req = 1'b0; kb_a = 32'h0; kb_wd = 32'h0;
    vga_req = 1'b0; vga_a = 32'h0;

    // reset cycle with requests up: nothing may be granted
    step;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 32'h10; kb_req = 1'b1;
    #1;
    check("rst_cpu_ack", 32'(cpu_ack), 32'h0);
    check("rst_kb_ack", 32'(kb_ack), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    check("rst_vga_rvalid", 32'(vga_rvalid), 32'h0);
    check("rst_cpu_rd", cpu_rd, 32'h0);
    check("rst_vga_rd", vga_rd, 32'h0);
    check("rst_addr_err", 32'(addr_err), 32'h0);
    cpu_req = 1'b0; kb_a = 32'h20; kb_wd = 32'h1234_5678;

    // clear sweep with a KB write held pending
    step;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1;
      check("clr_mem_we", 32'(mem_we), 32'h1);
      check("clr_mem_a", mem_a, 32'(i * 4));
      check("clr_mem_wd", mem_wd, 32'h0);
      check("clr_kb_ack", 32'(kb_ack), 32'h0);
      check("clr_ready", 32'(ready), 32'h0);
      step;
    end
    #1;
    check("run_ready", 32'(ready), 32'h1);
    check("kb_first_ack", 32'(kb_ack), 32'h1);
    check("kb_first_mem_a", mem_a, 32'h20);
    check("kb_first_mem_we", 32'(mem_we), 32'h1);
    check("kb_first_mem_wd", mem_wd, 32'h1234_5678);
    check("kb_first_addr_err", 32'(addr_err), 32'h0);

    // CPU write then read of 0x10
    step;
    kb_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 32'h10; cpu_wd = 32'hDEAD_BEEF;
    #1;
    check("cpu_wr_ack", 32'(cpu_ack), 32'h1);
    check("cpu_wr_mem_we", 32'(mem_we), 32'h1);
    check("cpu_wr_mem_a", mem_a, 32'h10);
    check("cpu_wr_mem_wd", mem_wd, 32'hDEAD_BEEF);
    step;
    cpu_we = 1'b0; cpu_q.push_back(32'hDEAD_BEEF);
    #1;
    check("cpu_rd_ack", 32'(cpu_ack), 32'h1);
    check("cpu_rd_mem_we", 32'(mem_we), 32'h0);
    step;
    cpu_req = 1'b0;
    #1;
    check("cpu_rvalid_next", 32'(cpu_rvalid), 32'h1);
    check("cpu_idle_ack", 32'(cpu_ack), 32'h0);
    step;
    #1;
    check("cpu_rvalid_drop", 32'(cpu_rvalid), 32'h0);
    check("cpu_rd_hold", cpu_rd, 32'hDEAD_BEEF);

    // back-to-back reads: KB-written word and a cleared word
    step;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 32'h20; cpu_q.push_back(32'h1234_5678);
    #1;
    check("b2b_ack0", 32'(cpu_ack), 32'h1);
    step;
    cpu_a = 32'h40; cpu_q.push_back(32'h0);
    #1;
    check("b2b_ack1", 32'(cpu_ack), 32'h1);
    check("b2b_rvalid", 32'(cpu_rvalid), 32'h1);
    step;
    cpu_req = 1'b0;
    #1;
    check("b2b_rvalid_last", 32'(cpu_rvalid), 32'h1);

    // three-way contention: CPU x8, then starving KB, then starving VGA
    step;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 32'h80;
    kb_req = 1'b1; kb_a = 32'h84; kb_wd = 32'hCAFE_0001;
    vga_req = 1'b1; vga_a = 32'h20; vga_q.push_back(32'h1234_5678);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step;
      cpu_wd = 32'(c);
      if (c == 9) kb_req = 1'b0;
      #1;
      check("arb_cpu_ack", 32'(cpu_ack), (c < 8) ? 32'h1 : 32'h0);
      check("arb_kb_ack", 32'(kb_ack), (c == 8) ? 32'h1 : 32'h0);
      check("arb_vga_ack", 32'(vga_ack), (c == 9) ? 32'h1 : 32'h0);
    end

    // out-of-range VGA read and KB write
    step;
    cpu_req = 1'b0; vga_a = 32'h100; vga_q.push_back(32'h0);
    #1;
    check("oor_vga_ack", 32'(vga_ack), 32'h1);
    check("oor_vga_err", 32'(addr_err), 32'h1);
    check("oor_vga_we", 32'(mem_we), 32'h0);
    step;
    vga_req = 1'b0; kb_req = 1'b1; kb_a = 32'h100; kb_wd = 32'h55;
    #1;
    check("oor_kb_ack", 32'(kb_ack), 32'h1);
    check("oor_kb_err", 32'(addr_err), 32'h1);
    check("oor_kb_we", 32'(mem_we), 32'h0);
    check("oor_vga_rvalid", 32'(vga_rvalid), 32'h1);
    step;
    kb_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 32'h84; cpu_q.push_back(32'hCAFE_0001);
    #1;
    check("post_oor_err", 32'(addr_err), 32'h0);
    check("post_oor_vga_rvalid", 32'(vga_rvalid), 32'h0);
    check("post_oor_vga_rd", vga_rd, 32'h0);
    check("rd84_ack", 32'(cpu_ack), 32'h1);
    step;
    cpu_a = 32'h80; cpu_q.push_back(32'h7);
    #1;
    check("rd80_ack", 32'(cpu_ack), 32'h1);
    step;
    cpu_a = 32'h10; cpu_q.push_back(32'hDEAD_BEEF);
    #1;
    check("rd10_ack", 32'(cpu_ack), 32'h1);

    // reset while a KB write is pending
    step;
    cpu_req = 1'b0; rst = 1'b1;
    kb_req = 1'b1; kb_a = 32'h30; kb_wd = 32'h77;
    #1;
    check("rst2_kb_ack", 32'(kb_ack), 32'h0);
    check("rst2_mem_we", 32'(mem_we), 32'h0);
    check("rst2_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
    step;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1;
      check("clr2_mem_a", mem_a, 32'(i * 4));
      check("clr2_mem_we", 32'(mem_we), 32'h1);
      check("clr2_kb_ack", 32'(kb_ack), 32'h0);
      check("clr2_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
      step;
    end
    #1;
    check("rst2_ready", 32'(ready), 32'h1);
    check("rst2_kb_late_ack", 32'(kb_ack), 32'h1);
    check("rst2_kb_mem_a", mem_a, 32'h30);
    check("rst2_kb_mem_wd", mem_wd, 32'h77);
    step;
    kb_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 32'h10; cpu_q.push_back(32'h0);
    #1;
    check("rd10_cleared_ack", 32'(cpu_ack), 32'h1);
    step;
    cpu_req = 1'b0;
    step;
    step;
    #1;
    check("cpu_q_drained", 32'(cpu_q.size()), 32'h0);
    check("vga_q_drained", 32'(vga_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
